// File: rtl/m_andn_pipe.sv
// rtl/m_andn_pipe.sv - pipelined wide-AND reduction with valid tracking, rise detect and optional sticky flag
//
// Reduces WIDTH input bits to a single AND result through LEVELS tree levels of
// GROUP-input AND nodes. Each level is registered, so a sample accepted on one
// edge shows up on B/BVALID/RISE LEVELS edges later, one sample per cycle.
//
// Optional feature macro: ANDN_STICKY_EN (builds the STICKY register and honours CLR).
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESETL  in   asynchronous active-low reset
//   A       in   WIDTH operand bits, sampled when AVALID=1
//   AVALID  in   A is meaningful this cycle
//   CLR     in   synchronous clear of STICKY (ignored without ANDN_STICKY_EN)
//   B       out  AND of the most recent valid sample (holds between samples)
//   BVALID  out  one-cycle pulse per accepted sample
//   RISE    out  valid result is 1 and the previous valid result was 0
//   STICKY  out  B has been 1 since the last CLR (0 without ANDN_STICKY_EN)

module m_andn_pipe #(
  parameter int WIDTH = 11,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic [WIDTH-1:0] A,
  input  logic             AVALID,
  input  logic             CLR,
  output logic             B,
  output logic             BVALID,
  output logic             RISE,
  output logic             STICKY
);

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int calc_levels(input int w, input int g);
    int l;
    int p;
    l = 1;
    p = g;
    while (p < w) begin
      l = l + 1;
      p = p * g;
    end
    return l;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, GROUP);
  // Input is padded with 1s up to a full tree so every node sees GROUP bits.
  localparam int PADW   = ipow(GROUP, LEVELS);

  // Level k consumes PADW/GROUP^k bits and produces PADW/GROUP^(k+1) bits.
  // All levels but the last are registered here; the last level's AND feeds
  // the output stage, which is itself the final pipeline register.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW = PADW / ipow(GROUP, k);
    localparam int OW = IW / GROUP;

    logic [IW-1:0] src;
    logic          src_vld;
    logic [OW-1:0] red;
    logic [OW-1:0] out;
    logic          out_vld;

    if (k == 0) begin : g_src
      always_comb begin
        src            = '1;
        src[WIDTH-1:0] = A;
      end
      assign src_vld = AVALID;
    end else begin : g_src
      assign src     = g_lvl[k-1].out;
      assign src_vld = g_lvl[k-1].out_vld;
    end

    always_comb begin
      red = '0;
      for (int j = 0; j < OW; j++) red[j] = &src[j*GROUP +: GROUP];
    end

    if (k < LEVELS - 1) begin : g_reg
      logic [OW-1:0] data_q;
      logic          vld_q;

      // Data loads every cycle; only the valid bit qualifies it downstream.
      always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          data_q <= red;
          vld_q  <= src_vld;
        end
      end

      assign out     = data_q;
      assign out_vld = vld_q;
    end else begin : g_last
      assign out     = red;
      assign out_vld = src_vld;
    end
  end

  logic final_and;
  logic final_vld;
  assign final_and = g_lvl[LEVELS-1].out[0];
  assign final_vld = g_lvl[LEVELS-1].out_vld;

  logic b_q;
  logic bvalid_q;
  logic rise_q;

  // b_q only changes on valid results, so it doubles as the "previous valid
  // result" used by the edge detector.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      b_q      <= 1'b0;
      bvalid_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      bvalid_q <= final_vld;
      rise_q   <= final_vld & final_and & ~b_q;
      if (final_vld) b_q <= final_and;
    end
  end

  assign B      = b_q;
  assign BVALID = bvalid_q;
  assign RISE   = rise_q;

`ifdef ANDN_STICKY_EN
  logic sticky_q;

  // A valid 1 on the same edge as CLR wins.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      sticky_q <= 1'b0;
    end else if (final_vld && final_and) begin
      sticky_q <= 1'b1;
    end else if (CLR) begin
      sticky_q <= 1'b0;
    end
  end

  assign STICKY = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = CLR;
  assign STICKY     = 1'b0;
`endif

endmodule

// File: tb/tb_m_andn_pipe.sv
// tb/tb_m_andn_pipe.sv - scoreboard bench for m_andn_pipe (WIDTH=11 and WIDTH=5, GROUP=4)

module tb_m_andn_pipe;

  localparam int LEVELS = 2;  // 4^2 >= 11 and 4^2 >= 5

  logic        CLK;
  logic        RESETL;
  logic [10:0] A1;
  logic [4:0]  A5;
  logic        AVALID;
  logic        CLR;
  logic        b1, bv1, r1, s1;
  logic        b5, bv5, r5, s5;

  m_andn_pipe #(.WIDTH(11), .GROUP(4)) u_dut11 (
    .CLK(CLK), .RESETL(RESETL), .A(A1), .AVALID(AVALID), .CLR(CLR),
    .B(b1), .BVALID(bv1), .RISE(r1), .STICKY(s1)
  );

  m_andn_pipe #(.WIDTH(5), .GROUP(4)) u_dut5 (
    .CLK(CLK), .RESETL(RESETL), .A(A5), .AVALID(AVALID), .CLR(CLR),
    .B(b5), .BVALID(bv5), .RISE(r5), .STICKY(s5)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int   cyc;
    logic b1;
    logic b5;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_check++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reference state is the last valid result and the sticky level
  // of each design; RISE is derived from those at comparison time.
  logic m_b1 = 1'b0, m_b5 = 1'b0, st1 = 1'b0, st5 = 1'b0;
  logic clr_s;

  initial begin
    exp_t e;
    logic exp_s1, exp_s5;
    forever begin
      @(posedge CLK);
      clr_s = CLR;
      cyc++;
      @(negedge CLK);
      if (!RESETL) begin
        q.delete();
        m_b1 = 1'b0; m_b5 = 1'b0; st1 = 1'b0; st5 = 1'b0;
        chk("rst_b11", b1, 1'b0);   chk("rst_bvalid11", bv1, 1'b0);
        chk("rst_rise11", r1, 1'b0); chk("rst_sticky11", s1, 1'b0);
        chk("rst_b5", b5, 1'b0);    chk("rst_bvalid5", bv5, 1'b0);
        chk("rst_rise5", r5, 1'b0);  chk("rst_sticky5", s5, 1'b0);
        continue;
      end
      chk("bvalid_match", bv5, bv1);
      if (bv1) begin
        if (q.size() == 0) begin
          chk("spurious_bvalid", bv1, 1'b0);
        end else begin
          e = q.pop_front();
          chk_int("latency", cyc - e.cyc, LEVELS);
          chk("b11", b1, e.b1);
          chk("rise11", r1, e.b1 & ~m_b1);
          chk("b5", b5, e.b5);
          chk("rise5", r5, e.b5 & ~m_b5);
          m_b1 = e.b1;
          m_b5 = e.b5;
          st1 = e.b1 ? 1'b1 : (clr_s ? 1'b0 : st1);
          st5 = e.b5 ? 1'b1 : (clr_s ? 1'b0 : st5);
        end
      end else begin
        if (q.size() > 0 && cyc - q[0].cyc >= LEVELS) begin
          chk("missing_bvalid", bv1, 1'b1);
          void'(q.pop_front());
        end
        chk("b11_hold", b1, m_b1);
        chk("rise11_idle", r1, 1'b0);
        chk("b5_hold", b5, m_b5);
        chk("rise5_idle", r5, 1'b0);
        if (clr_s) begin
          st1 = 1'b0;
          st5 = 1'b0;
        end
      end
`ifdef ANDN_STICKY_EN
      exp_s1 = st1;
      exp_s5 = st5;
`else
      exp_s1 = 1'b0;
      exp_s5 = 1'b0;
`endif
      chk("sticky11", s1, exp_s1);
      chk("sticky5", s5, exp_s5);
    end
  end

  task automatic issue(input logic v, input logic [10:0] a, input logic [4:0] a5, input logic clr);
    AVALID = v;
    A1     = a;
    A5     = a5;
    CLR    = clr;
    if (v) q.push_back('{cyc, (a == 11'h7FF), (a5 == 5'h1F)});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 11'h000, 5'h00, 1'b0);
  endtask

  function automatic logic [10:0] rand_a11();
    logic [10:0] v;
    case ($urandom_range(0, 3))
      0, 3:    v = 11'h7FF;
      1:       v = 11'h7FF & ~(11'h001 << $urandom_range(0, 10));
      default: v = 11'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [4:0] rand_a5();
    logic [4:0] v;
    case ($urandom_range(0, 3))
      0, 3:    v = 5'h1F;
      1:       v = 5'h1F & ~(5'h01 << $urandom_range(0, 4));
      default: v = 5'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    RESETL = 1'b0;
    AVALID = 1'b0;
    A1     = '0;
    A5     = '0;
    CLR    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESETL = 1'b1;

    // single sample after reset
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    idle(4);

    // single-bit clears, back-to-back
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    issue(1'b1, 11'h7FE, 5'h1E, 1'b0);
    issue(1'b1, 11'h3FF, 5'h0F, 1'b0);
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    idle(3);

    // bubbles
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    issue(1'b0, 11'h000, 5'h00, 1'b0);
    issue(1'b0, 11'h000, 5'h00, 1'b0);
    issue(1'b1, 11'h000, 5'h00, 1'b0);
    idle(3);

    // padding on the 5-bit instance
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    issue(1'b1, 11'h7FF, 5'h0F, 1'b0);
    idle(3);

    // sticky: set, hold through 0, CLR coincident with a valid 1, CLR alone
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    issue(1'b1, 11'h000, 5'h00, 1'b0);
    idle(3);
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    issue(1'b0, 11'h000, 5'h00, 1'b1);
    idle(2);
    issue(1'b0, 11'h000, 5'h00, 1'b1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 3) != 0), rand_a11(), rand_a5(), ($urandom_range(0, 6) == 0));
    end
    idle(4);

    // mid-flight reset discards the in-flight sample
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    AVALID = 1'b0;
    RESETL = 1'b0;
    @(posedge CLK);
    #1;
    RESETL = 1'b1;
    idle(5);

    // first sample after reset release
    issue(1'b1, 11'h7FF, 5'h1F, 1'b0);
    idle(5);

    chk_int("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_check - n_fail, n_check);
    $finish;
  end

endmodule
